// File: rtl/control_unit_mc.sv
// control_unit_mc: multicycle FETCH/EXEC/MEM/WB sequencer for the teaching CPU,
// with a load/store handshake and timeout, a return-address stack pointer, and sticky fault capture.
`default_nettype none

module control_unit_mc #(
    parameter int ALUOP_W     = 3,
    parameter int STACK_DEPTH = 8,
    parameter int MEM_TIMEOUT = 15
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic [5:0]                   opcode,
    input  logic                         zero,
    input  logic                         mem_ack,
    output logic                         ir_we,
    output logic                         pc_we,
    output logic [1:0]                   s_pc,
    output logic                         s_inm,
    output logic                         s_mem,
    output logic                         we3,
    output logic                         wez,
    output logic [ALUOP_W-1:0]           alu_op,
    output logic                         mem_req,
    output logic                         mem_we,
    output logic                         stack_push,
    output logic                         stack_pop,
    output logic [$clog2(STACK_DEPTH):0] sp,
    output logic                         fault,
    output logic [2:0]                   fault_code
);

    localparam int SPW   = $clog2(STACK_DEPTH) + 1;
    localparam int CNT_W = $clog2(MEM_TIMEOUT + 1);

    localparam logic [2:0] FC_ILLEGAL   = 3'b001;
    localparam logic [2:0] FC_OVERFLOW  = 3'b010;
    localparam logic [2:0] FC_UNDERFLOW = 3'b011;
    localparam logic [2:0] FC_TIMEOUT   = 3'b100;

    localparam logic [1:0] PC_INC = 2'b00;
    localparam logic [1:0] PC_IMM = 2'b01;
    localparam logic [1:0] PC_STK = 2'b10;

    typedef enum logic [1:0] {
        S_FETCH = 2'd0,
        S_EXEC  = 2'd1,
        S_MEM   = 2'd2,
        S_WB    = 2'd3
    } state_t;

    state_t             state_q, state_d;
    logic [SPW-1:0]     sp_q, sp_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               fault_q;
    logic [2:0]         fault_code_q;
    logic               fault_ev;
    logic [2:0]         fault_ev_code;

    always_comb begin
        ir_we         = 1'b0;
        pc_we         = 1'b0;
        s_pc          = PC_INC;
        s_inm         = 1'b0;
        s_mem         = 1'b0;
        we3           = 1'b0;
        wez           = 1'b0;
        alu_op        = '0;
        mem_req       = 1'b0;
        mem_we        = 1'b0;
        stack_push    = 1'b0;
        stack_pop     = 1'b0;
        state_d       = state_q;
        sp_d          = sp_q;
        cnt_d         = cnt_q;
        fault_ev      = 1'b0;
        fault_ev_code = 3'b000;

        // Gating on reset keeps mem_req low the moment reset rises, even mid-MEM.
        if (!reset) begin
            case (state_q)
                S_FETCH: begin
                    ir_we   = 1'b1;
                    state_d = S_EXEC;
                end
                S_EXEC: begin
                    state_d = S_FETCH;
                    pc_we   = 1'b1;
                    if (!opcode[5]) begin
                        we3    = 1'b1;
                        wez    = 1'b1;
                        alu_op = opcode[ALUOP_W+1:2];
                    end else if (!opcode[4]) begin
                        s_inm = 1'b1;
                        we3   = 1'b1;
                        wez   = 1'b1;
                        case (opcode[3:2])
                            2'b00: begin
                                alu_op = ALUOP_W'(0);
                                wez    = 1'b0;
                            end
                            2'b01:   alu_op = ALUOP_W'(2);
                            2'b10:   alu_op = ALUOP_W'(3);
                            default: alu_op = ALUOP_W'(6);
                        endcase
                    end else begin
                        case (opcode)
                            6'b110000, 6'b110001: begin
                                pc_we   = 1'b0;
                                mem_req = 1'b1;
                                mem_we  = opcode[0];
                                cnt_d   = CNT_W'(1);
                                state_d = S_MEM;
                            end
                            6'b110100: begin
                                if (sp_q == SPW'(STACK_DEPTH)) begin
                                    fault_ev      = 1'b1;
                                    fault_ev_code = FC_OVERFLOW;
                                end else begin
                                    stack_push = 1'b1;
                                    s_pc       = PC_IMM;
                                    sp_d       = sp_q + 1'b1;
                                end
                            end
                            6'b110101: begin
                                if (sp_q == '0) begin
                                    fault_ev      = 1'b1;
                                    fault_ev_code = FC_UNDERFLOW;
                                end else begin
                                    stack_pop = 1'b1;
                                    s_pc      = PC_STK;
                                    sp_d      = sp_q - 1'b1;
                                end
                            end
                            6'b111100: s_pc = PC_IMM;
                            6'b111101: s_pc = zero ? PC_IMM : PC_INC;
                            6'b111110: s_pc = zero ? PC_INC : PC_IMM;
                            default: begin
                                fault_ev      = 1'b1;
                                fault_ev_code = FC_ILLEGAL;
                            end
                        endcase
                    end
                end
                S_MEM: begin
                    // An ack on the limit cycle takes priority over the timeout.
                    if (mem_ack) begin
                        mem_req = 1'b1;
                        mem_we  = opcode[0];
                        cnt_d   = '0;
                        if (opcode[0]) begin
                            pc_we   = 1'b1;
                            state_d = S_FETCH;
                        end else begin
                            state_d = S_WB;
                        end
                    end else if (cnt_q == CNT_W'(MEM_TIMEOUT)) begin
                        pc_we         = 1'b1;
                        cnt_d         = '0;
                        fault_ev      = 1'b1;
                        fault_ev_code = FC_TIMEOUT;
                        state_d       = S_FETCH;
                    end else begin
                        mem_req = 1'b1;
                        mem_we  = opcode[0];
                        cnt_d   = cnt_q + 1'b1;
                    end
                end
                S_WB: begin
                    we3     = 1'b1;
                    s_mem   = 1'b1;
                    pc_we   = 1'b1;
                    state_d = S_FETCH;
                end
                default: state_d = S_FETCH;
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= S_FETCH;
            sp_q         <= '0;
            cnt_q        <= '0;
            fault_q      <= 1'b0;
            fault_code_q <= 3'b000;
        end else begin
            state_q <= state_d;
            sp_q    <= sp_d;
            cnt_q   <= cnt_d;
            if (fault_ev && !fault_q) begin
                fault_q      <= 1'b1;
                fault_code_q <= fault_ev_code;
            end
        end
    end

    assign sp         = sp_q;
    assign fault      = fault_q;
    assign fault_code = fault_code_q;

endmodule

`default_nettype wire

// File: tb/tb_control_unit_mc.sv
// Scoreboard bench for control_unit_mc: stimulus queues per-cycle expected outputs,
// a negedge monitor pops and compares them against the DUT.
`default_nettype none

module tb_control_unit_mc;

    localparam int TO = 15;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [5:0] opcode = 6'd0;
    logic       zero = 1'b0;
    logic       mem_ack = 1'b0;
    logic       ir_we, pc_we, s_inm, s_mem, we3, wez, mem_req, mem_we;
    logic       stack_push, stack_pop, fault;
    logic [1:0] s_pc;
    logic [2:0] alu_op, fault_code;
    logic [3:0] sp;

    control_unit_mc #(.ALUOP_W(3), .STACK_DEPTH(8), .MEM_TIMEOUT(TO)) dut (
        .clk(clk), .reset(reset), .opcode(opcode), .zero(zero), .mem_ack(mem_ack),
        .ir_we(ir_we), .pc_we(pc_we), .s_pc(s_pc), .s_inm(s_inm), .s_mem(s_mem),
        .we3(we3), .wez(wez), .alu_op(alu_op), .mem_req(mem_req), .mem_we(mem_we),
        .stack_push(stack_push), .stack_pop(stack_pop), .sp(sp),
        .fault(fault), .fault_code(fault_code)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic       ir_we;
        logic       pc_we;
        logic [1:0] s_pc;
        logic       s_inm;
        logic       s_mem;
        logic       we3;
        logic       wez;
        logic [2:0] alu_op;
        logic       mem_req;
        logic       mem_we;
        logic       push;
        logic       pop;
        logic [3:0] sp;
        logic       fault;
        logic [2:0] fcode;
    } vec_t;

    typedef struct {
        vec_t  v;
        string name;
    } item_t;

    item_t q[$];
    int    n_pass = 0;
    int    n_total = 0;

    logic [3:0] m_sp = 4'd0;
    logic       m_f = 1'b0;
    logic [2:0] m_c = 3'd0;

    vec_t act;
    assign act = {ir_we, pc_we, s_pc, s_inm, s_mem, we3, wez, alu_op, mem_req, mem_we,
                  stack_push, stack_pop, sp, fault, fault_code};

    always @(negedge clk) begin : monitor
        item_t it;
        if (q.size() > 0) begin
            it = q.pop_front();
            n_total++;
            if (act === it.v) n_pass++;
            else $display("FAIL %s: got %h expected %h", it.name, act, it.v);
        end
    end

    function automatic vec_t base();
        vec_t v;
        v       = '0;
        v.sp    = m_sp;
        v.fault = m_f;
        v.fcode = m_c;
        return v;
    endfunction

    task automatic cyc(input vec_t v, input string nm);
        item_t it;
        it.v    = v;
        it.name = nm;
        q.push_back(it);
        @(posedge clk);
        #1;
    endtask

    task automatic rec_fault(input logic [2:0] c);
        if (!m_f) begin
            m_f = 1'b1;
            m_c = c;
        end
    endtask

    task automatic do_reset();
        reset = 1'b1;
        m_sp  = 4'd0;
        m_f   = 1'b0;
        m_c   = 3'd0;
        cyc('0, "reset");
        cyc('0, "reset");
        reset = 1'b0;
    endtask

    task automatic fetch(input logic [5:0] op, input logic z);
        vec_t v;
        opcode  = op;
        zero    = z;
        v       = base();
        v.ir_we = 1'b1;
        cyc(v, "fetch");
    endtask

    task automatic do_alu(input logic [5:0] op, input logic stray_ack);
        vec_t v;
        mem_ack = stray_ack;
        fetch(op, 1'b0);
        v        = base();
        v.we3    = 1'b1;
        v.wez    = 1'b1;
        v.pc_we  = 1'b1;
        v.alu_op = op[4:2];
        cyc(v, "alu");
        mem_ack = 1'b0;
    endtask

    task automatic do_imm(input logic [5:0] op, input logic [2:0] alu, input logic wz, input string nm);
        vec_t v;
        fetch(op, 1'b0);
        v        = base();
        v.s_inm  = 1'b1;
        v.we3    = 1'b1;
        v.wez    = wz;
        v.pc_we  = 1'b1;
        v.alu_op = alu;
        cyc(v, nm);
    endtask

    task automatic do_jmp(input logic [5:0] op, input logic z, input logic [1:0] spc, input string nm);
        vec_t v;
        fetch(op, z);
        v       = base();
        v.pc_we = 1'b1;
        v.s_pc  = spc;
        cyc(v, nm);
    endtask

    task automatic do_jal();
        vec_t v;
        fetch(6'b110100, 1'b0);
        v       = base();
        v.pc_we = 1'b1;
        if (m_sp == 4'd8) begin
            cyc(v, "jal_overflow");
            rec_fault(3'b010);
        end else begin
            v.push = 1'b1;
            v.s_pc = 2'b01;
            cyc(v, "jal");
            m_sp = m_sp + 4'd1;
        end
    endtask

    task automatic do_ret();
        vec_t v;
        fetch(6'b110101, 1'b0);
        v       = base();
        v.pc_we = 1'b1;
        if (m_sp == 4'd0) begin
            cyc(v, "ret_underflow");
            rec_fault(3'b011);
        end else begin
            v.pop  = 1'b1;
            v.s_pc = 2'b10;
            cyc(v, "ret");
            m_sp = m_sp - 4'd1;
        end
    endtask

    task automatic do_illegal(input logic [5:0] op);
        vec_t v;
        fetch(op, 1'b0);
        v       = base();
        v.pc_we = 1'b1;
        cyc(v, "illegal");
        rec_fault(3'b001);
    endtask

    // ack_at: MEM counter value on which mem_ack arrives; 0 = never
    task automatic do_mem(input logic st, input int ack_at, input string nm);
        vec_t v;
        fetch(st ? 6'b110001 : 6'b110000, 1'b0);
        v         = base();
        v.mem_req = 1'b1;
        v.mem_we  = st;
        cyc(v, {nm, "_exec"});
        for (int c = 1; c <= TO; c++) begin
            v = base();
            if (c == ack_at) begin
                mem_ack   = 1'b1;
                v.mem_req = 1'b1;
                v.mem_we  = st;
                v.pc_we   = st;
                cyc(v, {nm, "_ack"});
                mem_ack = 1'b0;
                if (!st) begin
                    v       = base();
                    v.we3   = 1'b1;
                    v.s_mem = 1'b1;
                    v.pc_we = 1'b1;
                    cyc(v, {nm, "_wb"});
                end
                return;
            end else if (c == TO) begin
                v.pc_we = 1'b1;
                cyc(v, {nm, "_timeout"});
                rec_fault(3'b100);
                return;
            end else begin
                v.mem_req = 1'b1;
                v.mem_we  = st;
                cyc(v, {nm, "_wait"});
            end
        end
    endtask

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin : stim
        vec_t v;
        @(posedge clk);
        #1;
        do_reset();

        do_alu(6'b000100, 1'b0);
        do_alu(6'b000100, 1'b1);
        do_alu(6'b011100, 1'b0);

        do_imm(6'b100000, 3'b000, 1'b0, "li");
        do_imm(6'b100101, 3'b010, 1'b1, "adi");
        do_imm(6'b101010, 3'b011, 1'b1, "sbi");
        do_imm(6'b101111, 3'b110, 1'b1, "nai");

        do_jmp(6'b111100, 1'b0, 2'b01, "j");
        do_jmp(6'b111101, 1'b1, 2'b01, "jz_taken");
        do_jmp(6'b111101, 1'b0, 2'b00, "jz_not");
        do_jmp(6'b111110, 1'b1, 2'b00, "jnz_not");
        do_jmp(6'b111110, 1'b0, 2'b01, "jnz_taken");

        do_mem(1'b0, 2, "ld");
        do_mem(1'b1, TO, "st_ack_at_limit");
        do_mem(1'b1, 0, "st_no_ack");
        do_illegal(6'b111111);
        do_illegal(6'b110010);
        do_alu(6'b001000, 1'b0);

        do_reset();
        for (int i = 0; i < 9; i++) do_jal();
        for (int i = 0; i < 8; i++) do_ret();

        do_reset();
        do_ret();
        do_illegal(6'b111000);
        do_jal();

        // abort a load while mem_req is high
        fetch(6'b110000, 1'b0);
        v         = base();
        v.mem_req = 1'b1;
        cyc(v, "ld_abort_exec");
        v         = base();
        v.mem_req = 1'b1;
        cyc(v, "ld_abort_wait");
        do_reset();
        do_alu(6'b000100, 1'b0);

        for (int i = 0; i < 10 && q.size() > 0; i++) @(negedge clk);
        if (q.size() != 0) begin
            n_total++;
            $display("FAIL drain: got %0d pending expected 0", q.size());
        end
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/control_unit_mc.md
Name: control_unit_mc

Overview:
- Multicycle successor to the single-cycle control unit of the teaching CPU. Sequences FETCH/EXEC/MEM/WB per instruction and drives the PC mux, register file, zero flag, ALU, data memory handshake and a return-address stack.
- Adds load/store with req/ack and timeout, call/return with a bounded stack pointer, and sticky fault reporting.
- Sits between the instruction register and the datapath.

Parameters:
- ALUOP_W, 3, width of alu_op; the ALU field is opcode[ALUOP_W+1:2].
- STACK_DEPTH, 8, return-stack entries (power of 2, >=2).
- MEM_TIMEOUT, 15, max cycles waiting for mem_ack (>=1).

Ports:
- clk  in  1  clock
- reset  in  1  reset, asynchronous, active-high
- opcode  in  6  instruction-register opcode field, valid from EXEC onward
- zero  in  1  registered zero flag from datapath
- mem_ack  in  1  data-memory completion, one-cycle pulse
- ir_we  out  1  load instruction register
- pc_we  out  1  load PC
- s_pc  out  2  PC source: 00 PC+1, 01 immediate, 10 stack top
- s_inm  out  1  ALU operand B = immediate
- s_mem  out  1  regfile write data = memory read data
- we3  out  1  regfile write enable
- wez  out  1  zero-flag write enable
- alu_op  out  ALUOP_W  ALU function
- mem_req  out  1  data-memory request, held until ack or timeout
- mem_we  out  1  data-memory write, valid with mem_req
- stack_push  out  1  write PC+1 at stack[sp], then sp+1
- stack_pop  out  1  read stack[sp-1], then sp-1
- sp  out  clog2(STACK_DEPTH)+1  stack pointer
- fault  out  1  sticky fault flag
- fault_code  out  3  first fault cause: 001 illegal, 010 overflow, 011 underflow, 100 mem timeout

Behaviour:
- Registered state: fsm (FETCH, EXEC, MEM, WB), sp, timeout counter, fault, fault_code. Strobes are combinational from fsm, opcode, zero and sp.
- Reset: fsm=FETCH, sp=0, counter=0, fault=0, fault_code=000. While reset is high, every strobe is 0, s_pc=00, alu_op=0. mem_req drops asynchronously on reset, including mid-MEM.
- Strobes default to 0 in every state unless listed below.
- FETCH: ir_we=1 for one cycle; next state EXEC.
- EXEC decode:
  - 0xxxxx ALU reg-reg: we3=1, wez=1, alu_op=opcode[4:2], pc_we=1, s_pc=00. 2 cycles.
  - 1000xx LI: s_inm=1, we3=1, alu_op=000, wez=0.
  - 1001xx ADI: alu_op=010; 1010xx SBI: alu_op=011; 1011xx NAI: alu_op=110. All three with s_inm=1, we3=1, wez=1.
  - All immediate forms also assert pc_we=1, s_pc=00.
  - 111100 J: pc_we=1, s_pc=01.
  - 111101 JZ: pc_we=1, s_pc=01 if zero, else 00.
  - 111110 JNZ: pc_we=1, s_pc=01 if !zero, else 00.
  - 110100 JAL: stack_push=1, pc_we=1, s_pc=01, sp+1.
  - 110101 RET: stack_pop=1, pc_we=1, s_pc=10, sp-1.
  - 110000 LD and 110001 ST: mem_req=1 (mem_we=1 for ST), counter=1; next state MEM.
  - Non-memory instructions return to FETCH after EXEC.
- MEM: hold mem_req/mem_we. Counter increments each cycle.
  - On mem_ack, LD goes to WB; ST asserts pc_we=1, s_pc=00 and goes to FETCH.
  - If counter reaches MEM_TIMEOUT without ack: mem_req=0, pc_we=1, s_pc=00, fault code 100, go to FETCH.
  - mem_ack arriving in the same cycle the limit is reached wins; no fault.
- WB (LD only): we3=1, s_mem=1, wez=0, pc_we=1, s_pc=00; next state FETCH. LD therefore takes 3 + wait cycles.
- mem_ack outside MEM is ignored.
- JAL with sp==STACK_DEPTH: no push, no jump, sp unchanged, PC+1, fault 010.
- RET with sp==0: no pop, PC+1, fault 011.
- Any other opcode (1100 other than 00/01, 1101 other than 00/01, 1110xx, 111111): no writes, pc_we=1, s_pc=00, fault 001.
- Fault recording: fault sets on the first fault and fault_code captures its cause. Later faults leave fault_code unchanged; both clear only on reset. Execution continues after a fault.

Test Plan:
- Reset, then opcode 000100 (ALU op 001): FETCH then EXEC with we3=wez=pc_we=1, alu_op=001, s_pc=00; ir_we high every 2nd cycle.
- JZ 111101 with zero=1 -> s_pc=01; with zero=0 -> s_pc=00. JNZ 111110 is the inverse. pc_we=1 in both cases.
- LD 110000 with mem_ack 3 cycles after request: mem_req high 3 cycles, WB with we3=1, s_mem=1, pc_we=1; total 5 cycles; fault=0.
- ST 110001 with no ack, MEM_TIMEOUT=15: mem_req high exactly 15 cycles, then pc_we=1, fault=1, fault_code=100. A subsequent illegal 111111 keeps fault_code=100.
- 9 consecutive JALs with STACK_DEPTH=8: sp climbs 1..8; the 9th gives stack_push=0, s_pc=00, fault_code=010. Then 8 RETs bring sp to 0 with s_pc=10. A 9th RET on a fresh reset run gives fault_code=011.
- Assert reset while in MEM with mem_req=1: mem_req falls the same cycle; after release fsm=FETCH, sp=0, fault=0.
